// File: rtl/mem_port_if.sv
// Request/response and RAM bundle shared by the fetch port, the LSU port and the word RAM.
// slave is the arbiter's view; master is the requesters-plus-RAM view.
interface mem_port_if #(
  parameter int MEM_AW = 12
);
  // Handshake: a request transfers on the rising edge where *_req_valid && *_req_ready;
  // request fields must hold while valid && !ready; responses are single-cycle pulses with no backpressure.
  logic              i_req_valid;
  logic              i_req_ready;
  logic [31:0]       i_req_addr;
  logic              i_rsp_valid;
  logic [31:0]       i_rsp_data;
  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_we;
  logic [3:0]        d_req_wstrb;
  logic [31:0]       d_req_addr;
  logic [31:0]       d_req_wdata;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_data;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req_valid, i_req_addr,
    input  d_req_valid, d_req_we, d_req_wstrb, d_req_addr, d_req_wdata,
    input  mem_rdata,
    output i_req_ready, i_rsp_valid, i_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req_valid, i_req_addr,
    output d_req_valid, d_req_we, d_req_wstrb, d_req_addr, d_req_wdata,
    output mem_rdata,
    input  i_req_ready, i_rsp_valid, i_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store requests onto one single-port synchronous word RAM.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data priority with a fetch starvation guard.
module mem_port_arbiter #(
  parameter int MEM_AW     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_port_if.slave bus,
  output logic      dbg_state
);
  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              owner_d_q, owner_d_d;  // 1: the read in flight belongs to the data port
  logic              grant_i, grant_d;
  logic              i_win;
  logic              i_rsp_valid_q, i_rsp_valid_d;
  logic              d_rsp_valid_q, d_rsp_valid_d;
  logic [31:0]       i_rsp_data_q, i_rsp_data_d;
  logic [31:0]       d_rsp_data_q, d_rsp_data_d;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;

`ifdef MEM_ARB_RR_EN
  logic last_d_q, last_d_d;
  assign i_win = last_d_q;

  always_comb begin
    last_d_d = last_d_q;
    if (grant_d)      last_d_d = 1'b1;
    else if (grant_i) last_d_d = 1'b0;
  end
`else
  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  logic [SW-1:0] starve_q, starve_d;
  assign i_win = (starve_q == STARVE_LIM);

  // grant_d while fetch is valid can only mean fetch lost a contested cycle
  always_comb begin
    starve_d = starve_q;
    if (!bus.i_req_valid || grant_i) starve_d = '0;
    else if (grant_d)                starve_d = starve_q + STARVE_ONE;
  end
`endif

  always_comb begin
    state_d       = state_q;
    owner_d_d     = owner_d_q;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    i_rsp_valid_d = 1'b0;
    d_rsp_valid_d = 1'b0;
    i_rsp_data_d  = i_rsp_data_q;
    d_rsp_data_d  = d_rsp_data_q;
    mem_en        = 1'b0;
    mem_we        = 4'b0000;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state_q)
      IDLE: begin
        if (rst_n) begin
          if (bus.i_req_valid && bus.d_req_valid) begin
            grant_i = i_win;
            grant_d = !i_win;
          end else begin
            grant_i = bus.i_req_valid;
            grant_d = bus.d_req_valid;
          end
        end
        if (grant_d) begin
          mem_en   = 1'b1;
          mem_addr = bus.d_req_addr[MEM_AW+1:2];
          if (bus.d_req_we) begin
            mem_we        = bus.d_req_wstrb;
            mem_wdata     = bus.d_req_wdata;
            d_rsp_valid_d = 1'b1;
            d_rsp_data_d  = '0;
          end else begin
            state_d   = RD_WAIT;
            owner_d_d = 1'b1;
          end
        end else if (grant_i) begin
          mem_en    = 1'b1;
          mem_addr  = bus.i_req_addr[MEM_AW+1:2];
          state_d   = RD_WAIT;
          owner_d_d = 1'b0;
        end
      end
      RD_WAIT: begin
        state_d = IDLE;
        if (owner_d_q) begin
          d_rsp_valid_d = 1'b1;
          d_rsp_data_d  = bus.mem_rdata;
        end else begin
          i_rsp_valid_d = 1'b1;
          i_rsp_data_d  = bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_d_q     <= 1'b0;
      i_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      i_rsp_data_q  <= '0;
      d_rsp_data_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_d_q      <= 1'b1;
`else
      starve_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      owner_d_q     <= owner_d_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      i_rsp_data_q  <= i_rsp_data_d;
      d_rsp_data_q  <= d_rsp_data_d;
`ifdef MEM_ARB_RR_EN
      last_d_q      <= last_d_d;
`else
      starve_q      <= starve_d;
`endif
    end
  end

  assign bus.i_req_ready = grant_i;
  assign bus.d_req_ready = grant_d;
  assign bus.i_rsp_valid = i_rsp_valid_q;
  assign bus.i_rsp_data  = i_rsp_data_q;
  assign bus.d_rsp_valid = d_rsp_valid_q;
  assign bus.d_rsp_data  = d_rsp_data_q;
  assign bus.mem_en      = mem_en;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign dbg_state       = (state_q == RD_WAIT);

  // Byte-offset and above-array address bits are deliberately dropped; the space wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_req_addr[31:MEM_AW+2], bus.i_req_addr[1:0],
                              bus.d_req_addr[31:MEM_AW+2], bus.d_req_addr[1:0]};
endmodule
